// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter
//   Round-robin arbiter and access sequencer between two cache controllers
//   (ports A and B) and the shared system memory bus. Each grant produces one
//   strobed access, counts WAITSTATES memory wait states, captures read data
//   and returns a one-cycle Ready to the winning port.
//
// Parameters
//   ADDRWIDTH  : address width
//   DATAWIDTH  : data width
//   WAITSTATES : fixed memory wait states per access (0..15)
//
// Ports
//   Clk, Reset                    : clock, synchronous active-high reset
//   AStrobe/AAddress/ARW/AWData   : port A request (ARW 1 = read)
//   ARData/AReady                 : port A read data and completion pulse
//   BStrobe/BAddress/BRW/BWData   : port B request
//   BRData/BReady                 : port B read data and completion pulse
//   SysStrobe                     : one-cycle start-of-access pulse
//   SysAddress/SysRW/SysWData     : latched access address/direction/data
//   SysRData                      : memory read data, valid in last ACCESS cycle
//   SysGrant                      : one-hot owner {B,A}, 00 when idle
module sys_bus_arbiter #(
    parameter int ADDRWIDTH  = 16,
    parameter int DATAWIDTH  = 32,
    parameter int WAITSTATES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 AStrobe,
    input  logic [ADDRWIDTH-1:0] AAddress,
    input  logic                 ARW,
    input  logic [DATAWIDTH-1:0] AWData,
    output logic [DATAWIDTH-1:0] ARData,
    output logic                 AReady,
    input  logic                 BStrobe,
    input  logic [ADDRWIDTH-1:0] BAddress,
    input  logic                 BRW,
    input  logic [DATAWIDTH-1:0] BWData,
    output logic [DATAWIDTH-1:0] BRData,
    output logic                 BReady,
    output logic                 SysStrobe,
    output logic [ADDRWIDTH-1:0] SysAddress,
    output logic                 SysRW,
    output logic [DATAWIDTH-1:0] SysWData,
    input  logic [DATAWIDTH-1:0] SysRData,
    output logic [1:0]           SysGrant
);

    localparam logic [3:0] WAITCNT = 4'(WAITSTATES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic                 lastB;      // 1 when port B was granted last
    logic [DATAWIDTH-1:0] rDataReg;
    logic                 pickA;

    // A wins when it is the only requester, or on a tie when B went last.
    always_comb begin
        pickA = AStrobe && (!BStrobe || lastB);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lastB      <= 1'b1;
            rDataReg   <= '0;
            SysStrobe  <= 1'b0;
            SysAddress <= '0;
            SysRW      <= 1'b1;
            SysWData   <= '0;
            SysGrant   <= '0;
            AReady     <= 1'b0;
            BReady     <= 1'b0;
        end else begin
            SysStrobe <= 1'b0;
            AReady    <= 1'b0;
            BReady    <= 1'b0;
            case (state)
                IDLE: begin
                    if (AStrobe || BStrobe) begin
                        if (pickA) begin
                            SysAddress <= AAddress;
                            SysRW      <= ARW;
                            SysWData   <= AWData;
                            SysGrant   <= 2'b01;
                            lastB      <= 1'b0;
                        end else begin
                            SysAddress <= BAddress;
                            SysRW      <= BRW;
                            SysWData   <= BWData;
                            SysGrant   <= 2'b10;
                            lastB      <= 1'b1;
                        end
                        SysStrobe <= 1'b1;
                        cnt       <= WAITCNT;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Last ACCESS cycle: memory data is valid now.
                        if (SysRW) begin
                            rDataReg <= SysRData;
                        end
                        AReady <= SysGrant[0];
                        BReady <= SysGrant[1];
                        state  <= DONE;
                    end
                end
                DONE: begin
                    SysGrant <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ARData = rDataReg;
    assign BRData = rDataReg;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter
//   Drives two arbiter builds (WAITSTATES=2 and WAITSTATES=0) from shared
//   stimulus and compares every output each cycle against a transaction
//   timeline model: a grant starts a phase count, strobe is phase 0, Ready is
//   phase W+1, read data is captured at the end of phase W.
module tb_sys_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        aStrobe, bStrobe, aRW, bRW;
    logic [15:0] aAddress, bAddress;
    logic [31:0] aWData, bWData, sysRData;

    logic [31:0] aRData[2], bRData[2], sysWData[2];
    logic        aReady[2], bReady[2], sysStrobe[2], sysRW[2];
    logic [15:0] sysAddress[2];
    logic [1:0]  sysGrant[2];

    int tests = 0;
    int fails = 0;

    // Reference model state, one set per build
    int          waitOf[2] = '{2, 0};
    int          mPhase[2];
    logic        mOwnerB[2];
    logic        mLastB[2];
    logic [15:0] mAddr[2];
    logic        mRW[2];
    logic [31:0] mWData[2];
    logic [31:0] mRData[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sys_bus_arbiter #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAITSTATES(2)) dutW2 (
        .Clk(clk), .Reset(reset),
        .AStrobe(aStrobe), .AAddress(aAddress), .ARW(aRW), .AWData(aWData),
        .ARData(aRData[0]), .AReady(aReady[0]),
        .BStrobe(bStrobe), .BAddress(bAddress), .BRW(bRW), .BWData(bWData),
        .BRData(bRData[0]), .BReady(bReady[0]),
        .SysStrobe(sysStrobe[0]), .SysAddress(sysAddress[0]), .SysRW(sysRW[0]),
        .SysWData(sysWData[0]), .SysRData(sysRData), .SysGrant(sysGrant[0])
    );

    sys_bus_arbiter #(.ADDRWIDTH(16), .DATAWIDTH(32), .WAITSTATES(0)) dutW0 (
        .Clk(clk), .Reset(reset),
        .AStrobe(aStrobe), .AAddress(aAddress), .ARW(aRW), .AWData(aWData),
        .ARData(aRData[1]), .AReady(aReady[1]),
        .BStrobe(bStrobe), .BAddress(bAddress), .BRW(bRW), .BWData(bWData),
        .BRData(bRData[1]), .BReady(bReady[1]),
        .SysStrobe(sysStrobe[1]), .SysAddress(sysAddress[1]), .SysRW(sysRW[1]),
        .SysWData(sysWData[1]), .SysRData(sysRData), .SysGrant(sysGrant[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one rising edge to the model of build i using the sampled inputs.
    task automatic modelEdge(input int i);
        if (reset) begin
            mPhase[i] = -1;
            mLastB[i] = 1'b1;
            mAddr[i]  = '0;
            mRW[i]    = 1'b1;
            mWData[i] = '0;
            mRData[i] = '0;
        end else if (mPhase[i] < 0) begin
            if (aStrobe || bStrobe) begin
                // Sole requester wins; on a tie the port other than last wins.
                if (aStrobe && bStrobe) mOwnerB[i] = !mLastB[i];
                else                    mOwnerB[i] = bStrobe;
                mAddr[i]  = mOwnerB[i] ? bAddress : aAddress;
                mRW[i]    = mOwnerB[i] ? bRW      : aRW;
                mWData[i] = mOwnerB[i] ? bWData   : aWData;
                mLastB[i] = mOwnerB[i];
                mPhase[i] = 0;
            end
        end else begin
            if (mPhase[i] == waitOf[i] && mRW[i]) mRData[i] = sysRData;
            if (mPhase[i] == waitOf[i] + 1) mPhase[i] = -1;
            else                            mPhase[i]++;
        end
    endtask

    task automatic compare(input int i);
        logic [1:0] expGrant;
        logic       busy;
        busy     = (mPhase[i] >= 0);
        expGrant = !busy ? 2'b00 : (mOwnerB[i] ? 2'b10 : 2'b01);
        check($sformatf("grant[%0d]", i),  sysGrant[i], expGrant);
        check($sformatf("strobe[%0d]", i), sysStrobe[i], busy && mPhase[i] == 0);
        check($sformatf("aReady[%0d]", i), aReady[i],
              busy && mPhase[i] == waitOf[i] + 1 && !mOwnerB[i]);
        check($sformatf("bReady[%0d]", i), bReady[i],
              busy && mPhase[i] == waitOf[i] + 1 && mOwnerB[i]);
        check($sformatf("addr[%0d]", i),   sysAddress[i], mAddr[i]);
        check($sformatf("rw[%0d]", i),     sysRW[i], mRW[i]);
        check($sformatf("wdata[%0d]", i),  sysWData[i], mWData[i]);
        check($sformatf("aRData[%0d]", i), aRData[i], mRData[i]);
        check($sformatf("bRData[%0d]", i), bRData[i], mRData[i]);
    endtask

    // One clock: inputs are held across the rising edge, outputs are checked
    // at the falling edge, and the caller changes inputs afterwards.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) modelEdge(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) compare(i);
    endtask

    initial begin
        int          n;
        int          gStep[$];
        logic [1:0]  gVal[$];

        reset    = 1'b1;
        aStrobe  = 1'b0; bStrobe = 1'b0;
        aRW      = 1'b1; bRW     = 1'b1;
        aAddress = '0;   bAddress = '0;
        aWData   = '0;   bWData   = '0;
        sysRData = '0;
        for (int i = 0; i < 2; i++) begin
            mPhase[i] = -1; mOwnerB[i] = 1'b0; mLastB[i] = 1'b1;
        end

        // Reset state
        step(); step();
        check("rst_grant", sysGrant[0], 2'b00);
        check("rst_rw", sysRW[0], 1'b1);
        reset = 1'b0;
        step();

        // Single A read
        aStrobe = 1'b1; aAddress = 16'h1234; aRW = 1'b1; sysRData = 32'hDEADBEEF;
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) begin
                check("a_read_strobe", sysStrobe[0], 1'b1);
                check("a_read_addr", sysAddress[0], 16'h1234);
                check("a_read_grant", sysGrant[0], 2'b01);
            end
        end while (!aReady[0] && n < 20);
        check("a_read_latency", n, 4);
        check("a_read_data", aRData[0], 32'hDEADBEEF);
        check("a_read_no_bready", bReady[0], 1'b0);
        aStrobe = 1'b0;
        step(); step(); step();

        // Tie after reset: A,B,A,B every W+3 = 5 cycles
        reset = 1'b1; step(); reset = 1'b0;
        aStrobe = 1'b1; bStrobe = 1'b1; aRW = 1'b1; bRW = 1'b1;
        aAddress = 16'h0100; bAddress = 16'h0200; sysRData = 32'h0BADF00D;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (sysStrobe[0]) begin
                gStep.push_back(k);
                gVal.push_back(sysGrant[0]);
            end
        end
        check("tie_count", gVal.size(), 4);
        for (int j = 0; j < gVal.size() && j < 4; j++) begin
            check($sformatf("tie_grant%0d", j), gVal[j], (j % 2 == 1) ? 2'b10 : 2'b01);
            if (j > 0) check($sformatf("tie_gap%0d", j), gStep[j] - gStep[j-1], 5);
        end
        aStrobe = 1'b0; bStrobe = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // B write; read data register must keep its value
        bStrobe = 1'b1; bAddress = 16'h03FF; bRW = 1'b0; bWData = 32'hA5A5A5A5;
        sysRData = 32'h12345678;
        step();
        bStrobe = 1'b0;
        check("b_write_rw", sysRW[0], 1'b0);
        check("b_write_data", sysWData[0], 32'hA5A5A5A5);
        for (int k = 0; k < 5; k++) step();
        check("b_write_rdata_kept", bRData[0], 32'h0BADF00D);

        // B raised during an A access waits for IDLE
        aStrobe = 1'b1; aAddress = 16'h4444; aRW = 1'b1; sysRData = 32'h44440000;
        step();
        aStrobe = 1'b0; bStrobe = 1'b1; bAddress = 16'h5555; bRW = 1'b1;
        for (int k = 0; k < 6; k++) step();
        bStrobe = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Reset in the second ACCESS cycle, then a tie grants A
        aStrobe = 1'b1; aAddress = 16'h7777;
        step();
        aStrobe = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("mid_reset_grant", sysGrant[0], 2'b00);
        check("mid_reset_no_ready", aReady[0], 1'b0);
        reset = 1'b0;
        aStrobe = 1'b1; bStrobe = 1'b1;
        step();
        check("post_reset_tie", sysGrant[0], 2'b01);
        aStrobe = 1'b0; bStrobe = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            reset    = ($urandom_range(0, 49) == 0);
            aStrobe  = $urandom_range(0, 2) != 0;
            bStrobe  = $urandom_range(0, 2) != 0;
            aRW      = $urandom_range(0, 1) != 0;
            bRW      = $urandom_range(0, 1) != 0;
            aAddress = 16'($urandom);
            bAddress = 16'($urandom);
            aWData   = $urandom;
            bWData   = $urandom;
            sysRData = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
